// File: rtl/vi_debounce_multi.sv
// Multi-channel debouncer: 2-flop synchronizer, prescaled saturating integrator, hysteretic output, rise/fall strobes.
// Optional sticky per-channel glitch flags when VI_DEBOUNCE_GLITCH_CNT_EN is defined.
module vi_debounce_multi #(
    parameter int NCH        = 8,
    parameter int CNT_MAX    = 3,
    parameter int PRESC      = 1,
    parameter int INIT_LEVEL = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] in,
`ifdef VI_DEBOUNCE_GLITCH_CNT_EN
    input  logic           glitch_clr,
    output logic [NCH-1:0] glitch,
`endif
    output logic [NCH-1:0] debounced,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic           tick
);

    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_RST   = (INIT_LEVEL != 0) ? CNT_TOP : '0;
    localparam logic [NCH-1:0]   LVL_RST   = (INIT_LEVEL != 0) ? '1 : '0;
    localparam logic [PW-1:0]    PRESC_TOP = PW'(PRESC - 1);

    logic [NCH-1:0]   sync1_q, sync1_d;
    logic [NCH-1:0]   sync2_q, sync2_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] count_q [NCH];
    logic [CNT_W-1:0] count_d [NCH];
    logic [NCH-1:0]   deb_q, deb_d;
    logic [NCH-1:0]   rise_q, rise_d;
    logic [NCH-1:0]   fall_q, fall_d;

    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
        tick_d  = (presc_q == PRESC_TOP);
        presc_d = tick_d ? '0 : presc_q + PW'(1);
    end

    // The integrator only moves on the registered tick; the output flips when the next count hits a rail.
    always_comb begin
        deb_d = deb_q;
        for (int ch = 0; ch < NCH; ch++) begin
            count_d[ch] = count_q[ch];
            if (tick_q) begin
                if (sync2_q[ch] && (count_q[ch] < CNT_TOP)) begin
                    count_d[ch] = count_q[ch] + CNT_W'(1);
                end else if (!sync2_q[ch] && (count_q[ch] != '0)) begin
                    count_d[ch] = count_q[ch] - CNT_W'(1);
                end
            end
            if (count_d[ch] == CNT_TOP) begin
                deb_d[ch] = 1'b1;
            end else if (count_d[ch] == '0) begin
                deb_d[ch] = 1'b0;
            end
        end
        rise_d = deb_d & ~deb_q;
        fall_d = ~deb_d & deb_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= LVL_RST;
            sync2_q <= LVL_RST;
            presc_q <= '0;
            tick_q  <= 1'b0;
            deb_q   <= LVL_RST;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                count_q[ch] <= CNT_RST;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            deb_q   <= deb_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int ch = 0; ch < NCH; ch++) begin
                count_q[ch] <= count_d[ch];
            end
        end
    end

    assign debounced = deb_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign tick      = tick_q;

`ifdef VI_DEBOUNCE_GLITCH_CNT_EN
    logic [NCH-1:0] prev_s2_q, prev_s2_d;
    logic [NCH-1:0] glitch_q, glitch_d;

    // A glitch is a transition that started (count left the rail) but the input fell back before finishing.
    always_comb begin
        prev_s2_d = prev_s2_q;
        glitch_d  = glitch_q;
        if (tick_q) begin
            prev_s2_d = sync2_q;
            for (int ch = 0; ch < NCH; ch++) begin
                if ((sync2_q[ch] == deb_q[ch]) && (count_q[ch] != '0) && (count_q[ch] != CNT_TOP)
                    && (prev_s2_q[ch] != deb_q[ch])) begin
                    glitch_d[ch] = 1'b1;
                end
            end
        end
        if (glitch_clr) begin
            glitch_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_s2_q <= LVL_RST;
            glitch_q  <= '0;
        end else begin
            prev_s2_q <= prev_s2_d;
            glitch_q  <= glitch_d;
        end
    end

    assign glitch = glitch_q;
`endif

endmodule
